// File: rtl/operand_bypass_issue_if.sv
// Decoder-to-execute issue bus: decoded instruction in, bypass network, registered issue out.
// master drives the upstream/bypass/execute-ready side; slave is the issue stage.
interface operand_bypass_issue_if #(
  parameter int XLEN      = 64,
  parameter int NUM_BYP   = 2,
  parameter int PC_W      = 48,
  parameter int INST_W    = 32,
  parameter int PAYLOAD_W = 32,
  parameter int CNT_W     = 32
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [4:0]                in_rs1;
  logic [4:0]                in_rs2;
  logic [4:0]                in_rd;
  logic                      in_src1_is_reg;
  logic                      in_src2_is_reg;
  logic [XLEN-1:0]           in_rs1_data;
  logic [XLEN-1:0]           in_rs2_data;
  logic [XLEN-1:0]           in_src1;
  logic [XLEN-1:0]           in_src2;
  logic                      in_need_to_wb;
  logic [PC_W-1:0]           in_pc;
  logic [INST_W-1:0]         in_inst;
  logic [PAYLOAD_W-1:0]      in_payload;
  logic [NUM_BYP-1:0]        byp_valid;
  logic [NUM_BYP*5-1:0]      byp_rd;
  logic [NUM_BYP-1:0]        byp_data_ready;
  logic [NUM_BYP*XLEN-1:0]   byp_result;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out_src1;
  logic [XLEN-1:0]           out_src2;
  logic [4:0]                out_rd;
  logic                      out_need_to_wb;
  logic [PC_W-1:0]           out_pc;
  logic [INST_W-1:0]         out_inst;
  logic [PAYLOAD_W-1:0]      out_payload;
  logic [CNT_W-1:0]          stall_count;

  modport master (
    output flush, in_valid, in_rs1, in_rs2, in_rd, in_src1_is_reg, in_src2_is_reg,
           in_rs1_data, in_rs2_data, in_src1, in_src2, in_need_to_wb, in_pc, in_inst,
           in_payload, byp_valid, byp_rd, byp_data_ready, byp_result, out_ready,
    input  in_ready, out_valid, out_src1, out_src2, out_rd, out_need_to_wb, out_pc,
           out_inst, out_payload, stall_count
  );

  modport slave (
    input  flush, in_valid, in_rs1, in_rs2, in_rd, in_src1_is_reg, in_src2_is_reg,
           in_rs1_data, in_rs2_data, in_src1, in_src2, in_need_to_wb, in_pc, in_inst,
           in_payload, byp_valid, byp_rd, byp_data_ready, byp_result, out_ready,
    output in_ready, out_valid, out_src1, out_src2, out_rd, out_need_to_wb, out_pc,
           out_inst, out_payload, stall_count
  );
endinterface

// File: rtl/operand_bypass_issue.sv
// Issue stage with prioritised operand bypass; 1-cycle accept-to-issue latency, full throughput.
// Backpressure: in_ready drops on load-use hazard, flush, or a held output that execute has not taken.
module operand_bypass_issue #(
  parameter int XLEN      = 64,
  parameter int NUM_BYP   = 2,
  parameter int PC_W      = 48,
  parameter int INST_W    = 32,
  parameter int PAYLOAD_W = 32,
  parameter int CNT_W     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  operand_bypass_issue_if.slave bus
);

  // Returns {hazard, operand}. Index 0 is youngest, so the first match wins and
  // a not-yet-ready youngest writer hides any older ready copy of the register.
  function automatic logic [XLEN:0] resolve(
    input logic                    is_reg,
    input logic [4:0]              rs,
    input logic [XLEN-1:0]         rdata,
    input logic [XLEN-1:0]         alt,
    input logic [NUM_BYP-1:0]      bv,
    input logic [NUM_BYP*5-1:0]    brd,
    input logic [NUM_BYP-1:0]      bdr,
    input logic [NUM_BYP*XLEN-1:0] bres
  );
    logic            hit;
    logic            haz;
    logic [XLEN-1:0] val;
    hit = 1'b0;
    haz = 1'b0;
    val = rdata;
    if (!is_reg) begin
      val = alt;
    end else if (rs == 5'd0) begin
      val = '0;
    end else begin
      for (int i = 0; i < NUM_BYP; i++) begin
        if (!hit && bv[i] && brd[5*i +: 5] == rs) begin
          hit = 1'b1;
          if (bdr[i]) val = bres[XLEN*i +: XLEN];
          else        haz = 1'b1;
        end
      end
    end
    return {haz, val};
  endfunction

  logic [XLEN:0]        res1;
  logic [XLEN:0]        res2;
  logic                 hazard;
  logic                 accept;
  logic                 valid_q;
  logic [XLEN-1:0]      src1_q;
  logic [XLEN-1:0]      src2_q;
  logic [4:0]           rd_q;
  logic                 wb_q;
  logic [PC_W-1:0]      pc_q;
  logic [INST_W-1:0]    inst_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [CNT_W-1:0]     stall_q;

  always_comb begin
    res1 = resolve(bus.in_src1_is_reg, bus.in_rs1, bus.in_rs1_data, bus.in_src1,
                   bus.byp_valid, bus.byp_rd, bus.byp_data_ready, bus.byp_result);
    res2 = resolve(bus.in_src2_is_reg, bus.in_rs2, bus.in_rs2_data, bus.in_src2,
                   bus.byp_valid, bus.byp_rd, bus.byp_data_ready, bus.byp_result);
  end

  assign hazard       = bus.in_valid & (res1[XLEN] | res2[XLEN]);
  assign bus.in_ready = !bus.flush & !hazard & (!valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      payload_q <= '0;
      stall_q   <= '0;
    end else begin
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q   <= 1'b1;
        src1_q    <= res1[XLEN-1:0];
        src2_q    <= res2[XLEN-1:0];
        rd_q      <= bus.in_rd;
        wb_q      <= bus.in_need_to_wb;
        pc_q      <= bus.in_pc;
        inst_q    <= bus.in_inst;
        payload_q <= bus.in_payload;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
      // Counts hazard stalls only; survives flush so redirect-heavy phases still show load-use cost.
      if (hazard && !bus.flush && stall_q != '1) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_src1       = src1_q;
  assign bus.out_src2       = src2_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_need_to_wb = wb_q;
  assign bus.out_pc         = pc_q;
  assign bus.out_inst       = inst_q;
  assign bus.out_payload    = payload_q;
  assign bus.stall_count    = stall_q;

endmodule
